// File: rtl/pipelined_adder_pkg.sv
// Shared datapath definitions: flag bit positions and the add/sub opcode,
// also used by the ALU decoder.
package pipelined_adder_pkg;

    localparam int CARRY  = 0;
    localparam int OVF    = 1;
    localparam int ZERO   = 2;
    localparam int FLAG_W = 3;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/pipelined_adder_add_stage.sv
// One CHUNK-bit ripple slice of the pipelined adder with its stage registers.
// Operands and already-summed chunks ride along at full width.
module add_stage
    import pipelined_adder_pkg::*;
#(
    parameter int SIZE  = 32,
    parameter int CHUNK = 8,
    parameter int IDX   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            adv_i,
    input  logic            valid_i,
    input  logic [SIZE-1:0] a_i,
    input  logic [SIZE-1:0] b_i,
    input  logic [SIZE-1:0] s_i,
    input  logic            carry_i,
    output logic            valid_o,
    output logic [SIZE-1:0] a_o,
    output logic [SIZE-1:0] b_o,
    output logic [SIZE-1:0] s_o,
    output logic            carry_o,
    output logic [SIZE-1:0] sum_next_o,
    output logic            carry_next_o
);

    localparam int LO = IDX * CHUNK;

    logic            valid_q;
    logic [SIZE-1:0] a_q;
    logic [SIZE-1:0] b_q;
    logic [SIZE-1:0] s_q;
    logic            carry_q;

    logic [SIZE-1:0] sum_d;
    logic            carry_d;

    // Ripple only this stage's chunk; every other bit of the sum passes through.
    always_comb begin
        sum_d   = s_i;
        carry_d = carry_i;
        for (int i = 0; i < CHUNK; i++) begin
            sum_d[LO+i] = a_i[LO+i] ^ b_i[LO+i] ^ carry_d;
            carry_d     = (a_i[LO+i] & b_i[LO+i]) | (carry_d & (a_i[LO+i] ^ b_i[LO+i]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
        end else if (adv_i) begin
            valid_q <= valid_i;
            a_q     <= a_i;
            b_q     <= b_i;
            s_q     <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign valid_o      = valid_q;
    assign a_o          = a_q;
    assign b_o          = b_q;
    assign s_o          = s_q;
    assign carry_o      = carry_q;
    assign sum_next_o   = sum_d;
    assign carry_next_o = carry_d;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: SIZE/CHUNK ripple stages behind a valid/ready
// handshake, with carry, signed-overflow and zero flags on each result.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int SIZE  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] X,
    input  logic [SIZE-1:0] Y,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] S,
    output logic            Cout,
    output logic            overflow,
    output logic            zero
);

    localparam int STAGES = SIZE / CHUNK;

    if (SIZE % CHUNK != 0) begin : g_bad_chunk
        $error("pipelined_adder: CHUNK must divide SIZE exactly");
    end

    logic            advance;
    logic            valid_c   [STAGES+1];
    logic [SIZE-1:0] a_c       [STAGES+1];
    logic [SIZE-1:0] b_c       [STAGES+1];
    logic [SIZE-1:0] s_c       [STAGES+1];
    logic            carry_c   [STAGES+1];
    logic [SIZE-1:0] sum_nx    [STAGES];
    logic            carry_nx  [STAGES];

    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_d;
    logic              isSub;

    // The whole pipeline moves together; a held result freezes every stage.
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign isSub     = (op_e'(sub) == OP_SUB);

    assign valid_c[0] = in_valid;
    assign a_c[0]     = X;
    assign b_c[0]     = isSub ? ~Y : Y;
    assign s_c[0]     = '0;
    assign carry_c[0] = isSub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        add_stage #(
            .SIZE  (SIZE),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk          (clk),
            .rst          (rst),
            .adv_i        (advance),
            .valid_i      (valid_c[k]),
            .a_i          (a_c[k]),
            .b_i          (b_c[k]),
            .s_i          (s_c[k]),
            .carry_i      (carry_c[k]),
            .valid_o      (valid_c[k+1]),
            .a_o          (a_c[k+1]),
            .b_o          (b_c[k+1]),
            .s_o          (s_c[k+1]),
            .carry_o      (carry_c[k+1]),
            .sum_next_o   (sum_nx[k]),
            .carry_next_o (carry_nx[k])
        );
    end

    // Flags are computed from the last stage's completed sum and registered
    // alongside it, so they read 0 out of reset rather than zero=1.
    always_comb begin
        flags_d        = '0;
        flags_d[CARRY] = carry_nx[STAGES-1];
        flags_d[OVF]   = (a_c[STAGES-1][SIZE-1] == b_c[STAGES-1][SIZE-1]) &&
                         (sum_nx[STAGES-1][SIZE-1] != a_c[STAGES-1][SIZE-1]);
        flags_d[ZERO]  = (sum_nx[STAGES-1] == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else if (advance) begin
            flags_q <= flags_d;
        end
    end

    assign out_valid = valid_c[STAGES];
    assign S         = s_c[STAGES];
    assign Cout      = flags_q[CARRY];
    assign overflow  = flags_q[OVF];
    assign zero      = flags_q[ZERO];

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed corner cases, streaming,
// backpressure, mid-stream reset and a single-stage (CHUNK=SIZE) instance.
module tb_pipelined_adder;

    localparam int SIZE   = 32;
    localparam int CHUNK  = 8;
    localparam int STAGES = SIZE / CHUNK;
    localparam longint SMAX = (longint'(1) <<< 31) - 1;
    localparam longint SMIN = -(longint'(1) <<< 31);

    typedef struct packed {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inValid = 1'b0;
    logic        subOp = 1'b0;
    logic        outReady = 1'b1;
    logic [31:0] opX = '0;
    logic [31:0] opY = '0;
    logic        inReady, outValid, cout, ovf, zeroFlag;
    logic [31:0] sum;

    logic        inValid32 = 1'b0;
    logic        outReady32 = 1'b1;
    logic        inReady32, outValid32, cout32, ovf32, zeroFlag32;
    logic [31:0] sum32;

    res_t expQ[$];
    int   checks = 0;
    int   failures = 0;
    int   accepted = 0;
    int   delivered = 0;

    logic obsValid, obsReady, obsValid32;
    res_t obsRes, obsRes32, held;

    pipelined_adder #(.SIZE(SIZE), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
        .X(opX), .Y(opY), .sub(subOp), .out_valid(outValid), .out_ready(outReady),
        .S(sum), .Cout(cout), .overflow(ovf), .zero(zeroFlag)
    );

    pipelined_adder #(.SIZE(SIZE), .CHUNK(SIZE)) dut32 (
        .clk(clk), .rst(rst), .in_valid(inValid32), .in_ready(inReady32),
        .X(opX), .Y(opY), .sub(subOp), .out_valid(outValid32), .out_ready(outReady32),
        .S(sum32), .Cout(cout32), .overflow(ovf32), .zero(zeroFlag32)
    );

    always #5 clk = ~clk;

    // Reference result from plain wide-integer arithmetic on the operands.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic op);
        longint ux, uy, sx, sy, full, sr;
        res_t r;
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!op) begin
            full   = ux + uy;
            sr     = sx + sy;
            r.cout = full[32];
        end else begin
            full   = ux - uy;
            sr     = sx - sy;
            r.cout = (ux >= uy);
        end
        r.s    = full[31:0];
        r.ovf  = (sr > SMAX) || (sr < SMIN);
        r.zero = (r.s == 32'd0);
        return r;
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock: sample at the falling edge, score any transfers, then step.
    task automatic applyStimulus();
        res_t e;
        @(negedge clk);
        obsValid   = outValid;
        obsReady   = inReady;
        obsRes     = {sum, cout, ovf, zeroFlag};
        obsValid32 = outValid32;
        obsRes32   = {sum32, cout32, ovf32, zeroFlag32};
        if (outValid && outReady && !rst) begin
            checks++;
            assert (expQ.size() > 0)
            else begin
                failures++;
                $error("[TB] FAIL unexpected_result observed=%0h expected=none", sum);
            end
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checks++;
                assert (obsRes === e)
                else begin
                    failures++;
                    $error("[TB] FAIL scoreboard observed=%0h expected=%0h", obsRes, e);
                end
                delivered++;
            end
        end
        if (inValid && inReady && !rst) begin
            expQ.push_back(model(opX, opY, subOp));
            accepted++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic runSingle(input logic [31:0] x, input logic [31:0] y, input logic op, input string tag);
        opX = x; opY = y; subOp = op; inValid = 1'b1; outReady = 1'b1;
        applyStimulus();
        inValid = 1'b0;
        for (int j = 1; j <= STAGES; j++) begin
            applyStimulus();
            checkOutput({tag, "_latency"}, 64'(obsValid), 64'(j == STAGES));
        end
    endtask

    task automatic run32(input logic [31:0] x, input logic [31:0] y, input logic op, input string tag);
        opX = x; opY = y; subOp = op; inValid32 = 1'b1; inValid = 1'b0;
        applyStimulus();
        checkOutput({tag, "_idle"}, 64'(obsValid32), 64'(0));
        inValid32 = 1'b0;
        applyStimulus();
        checkOutput({tag, "_valid"}, 64'(obsValid32), 64'(1));
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int startAcc;

        // Reset held for two cycles.
        rst = 1'b1;
        repeat (2) applyStimulus();
        checkOutput("rst_valid", 64'(obsValid), 64'(0));
        checkOutput("rst_result", 64'(obsRes), 64'(0));
        checkOutput("rst_valid32", 64'(obsValid32), 64'(0));
        rst = 1'b0;
        applyStimulus();
        checkOutput("post_rst_ready", 64'(obsReady), 64'(1));
        checkOutput("post_rst_result", 64'(obsRes), 64'(0));

        runSingle(32'hFFFF_FFFF, 32'h1, 1'b0, "carry");
        checkOutput("carry_S", 64'(obsRes.s), 64'(32'h0));
        checkOutput("carry_Cout", 64'(obsRes.cout), 64'(1));
        checkOutput("carry_zero", 64'(obsRes.zero), 64'(1));
        checkOutput("carry_ovf", 64'(obsRes.ovf), 64'(0));

        runSingle(32'd5, 32'd7, 1'b1, "sub5m7");
        checkOutput("sub5m7_S", 64'(obsRes.s), 64'(32'hFFFF_FFFE));
        checkOutput("sub5m7_Cout", 64'(obsRes.cout), 64'(0));
        checkOutput("sub5m7_ovf", 64'(obsRes.ovf), 64'(0));

        runSingle(32'h8000_0000, 32'd1, 1'b1, "subMin");
        checkOutput("subMin_S", 64'(obsRes.s), 64'(32'h7FFF_FFFF));
        checkOutput("subMin_Cout", 64'(obsRes.cout), 64'(1));
        checkOutput("subMin_ovf", 64'(obsRes.ovf), 64'(1));

        runSingle(32'h7FFF_FFFF, 32'd1, 1'b0, "addMax");
        checkOutput("addMax_S", 64'(obsRes.s), 64'(32'h8000_0000));
        checkOutput("addMax_ovf", 64'(obsRes.ovf), 64'(1));
        checkOutput("addMax_Cout", 64'(obsRes.cout), 64'(0));

        // Eight back-to-back beats must come out as eight consecutive results.
        outReady = 1'b1;
        for (int t = 0; t < 8 + STAGES; t++) begin
            inValid = (t < 8);
            opX = pickOperand(); opY = pickOperand(); subOp = 1'($urandom_range(0, 1));
            applyStimulus();
            checkOutput("stream_valid", 64'(obsValid), 64'((t >= STAGES) && (t < 8 + STAGES)));
        end
        checkOutput("stream_drained", 64'(expQ.size()), 64'(0));

        // Fill, then stall for five cycles while offering beats that must be ignored.
        for (int t = 0; t < 6; t++) begin
            inValid = 1'b1;
            opX = pickOperand(); opY = pickOperand(); subOp = 1'($urandom_range(0, 1));
            applyStimulus();
        end
        outReady = 1'b0;
        for (int t = 0; t < 5; t++) begin
            opX = $urandom; opY = $urandom;
            applyStimulus();
            if (t == 0) held = obsRes;
            checkOutput("stall_ready", 64'(obsReady), 64'(0));
            checkOutput("stall_valid", 64'(obsValid), 64'(1));
            checkOutput("stall_hold", 64'(obsRes), 64'(held));
        end
        outReady = 1'b1;
        inValid  = 1'b0;
        repeat (STAGES + 2) applyStimulus();
        checkOutput("stall_drained", 64'(expQ.size()), 64'(0));
        checkOutput("stall_count", 64'(accepted - delivered), 64'(0));

        // Random valid and backpressure over 1000 accepted beats.
        startAcc = accepted;
        for (int n = 0; n < 20000 && accepted < startAcc + 1000; n++) begin
            inValid  = ($urandom_range(0, 3) != 0);
            outReady = ($urandom_range(0, 2) != 0);
            opX = pickOperand(); opY = pickOperand(); subOp = 1'($urandom_range(0, 1));
            applyStimulus();
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        for (int n = 0; n < 50 && expQ.size() > 0; n++) applyStimulus();
        checkOutput("random_beats", 64'(accepted - startAcc), 64'(1000));
        checkOutput("random_drained", 64'(expQ.size()), 64'(0));

        // Reset with three beats in flight; a beat offered during reset is dropped.
        for (int t = 0; t < 3; t++) begin
            inValid = 1'b1;
            opX = $urandom; opY = $urandom; subOp = 1'($urandom_range(0, 1));
            applyStimulus();
        end
        rst = 1'b1;
        applyStimulus();
        expQ.delete();
        rst = 1'b0;
        inValid = 1'b0;
        for (int t = 0; t < STAGES + 2; t++) begin
            applyStimulus();
            checkOutput("flush_valid", 64'(obsValid), 64'(0));
        end
        runSingle(32'h1234_5678, 32'h1111_1111, 1'b0, "post_flush");
        checkOutput("post_flush_S", 64'(obsRes.s), 64'(32'h2345_6789));

        // Single-stage instance: latency of one cycle.
        run32(32'hFFFF_FFFF, 32'h1, 1'b0, "c32_carry");
        checkOutput("c32_carry_S", 64'(obsRes32.s), 64'(32'h0));
        checkOutput("c32_carry_Cout", 64'(obsRes32.cout), 64'(1));
        checkOutput("c32_carry_zero", 64'(obsRes32.zero), 64'(1));
        checkOutput("c32_carry_ovf", 64'(obsRes32.ovf), 64'(0));
        run32(32'd5, 32'd7, 1'b1, "c32_sub");
        checkOutput("c32_sub_S", 64'(obsRes32.s), 64'(32'hFFFF_FFFE));
        checkOutput("c32_sub_Cout", 64'(obsRes32.cout), 64'(0));
        run32(32'h8000_0000, 32'd1, 1'b1, "c32_subMin");
        checkOutput("c32_subMin_S", 64'(obsRes32.s), 64'(32'h7FFF_FFFF));
        checkOutput("c32_subMin_ovf", 64'(obsRes32.ovf), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
